// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC32 constants, frame length limits, the MAC TX state
// encoding and a byte-wide reflected CRC32 step reused by the TX and RX paths.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          ETH_MIN_LEN     = 60;
  localparam int          ETH_MAX_LEN     = 1514;
  localparam int          ETH_IFG_CYCLES  = 12;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    TRUNC,
    PAD,
    FCS,
    IFG
  } mac_tx_state_t;

  // One byte through the reflected CRC32, bit 0 of the byte first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_mac_tx_if.sv
// Byte streams around the MAC transmit framer: user side (in_*) and PCS side (tx_*).
interface eth_mac_tx_if;

  // in_*: a byte moves on a clock edge where in_valid && in_ready; in_ready never waits on
  // in_valid. tx_*: a byte moves on an edge where tx_valid && !tx_pause; while paused the
  // sender holds tx_data/tx_eof stable.
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_eof;
  logic       tx_pause;

  modport slave (
    input  in_valid, in_data, in_last, tx_pause,
    output in_ready, tx_valid, tx_data, tx_eof
  );

  modport master (
    output in_valid, in_data, in_last, tx_pause,
    input  in_ready, tx_valid, tx_data, tx_eof
  );

endinterface

// File: rtl/crc32_d8_reg.sv
// Registered byte-wide CRC32 accumulator with synchronous clear and update enable.
module crc32_d8_reg
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc32_d8(crc, data);
    end
  end

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet MAC TX framer: pads to MIN_LEN, truncates at MAX_LEN, appends the FCS and enforces IFG.
// Define ETH_MAC_TX_STATS_EN to add the stat_frames / stat_trunc counters.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int MAX_LEN    = ETH_MAX_LEN,
  parameter int IFG_CYCLES = ETH_IFG_CYCLES
) (
  input  logic          clk,
  input  logic          reset_n,
  eth_mac_tx_if.slave   bus,
  output mac_tx_state_t dbg_state
`ifdef ETH_MAC_TX_STATS_EN
  ,
  output logic [31:0]   stat_frames,
  output logic [15:0]   stat_trunc
`endif
);

  mac_tx_state_t state, state_nxt;
  logic [10:0]   len;
  logic [10:0]   len_in;
  logic [15:0]   cnt;
  logic          trunc;
  logic [31:0]   crc;
  logic [31:0]   fcs;
  logic          ld_ok, rdy, accept;
  logic          load, load_eof, crc_en, crc_clr;
  logic [7:0]    load_data;

  // The output register may take a new value whenever it is empty or its byte is leaving.
  assign ld_ok  = !bus.tx_valid || !bus.tx_pause;
  assign rdy    = reset_n && (((state == IDLE) || (state == DATA)) ? ld_ok : (state == TRUNC));
  assign accept = bus.in_valid && rdy;
  assign len_in = (state == IDLE) ? 11'd1 : len + 11'd1;
  assign fcs    = trunc ? crc : ~crc;

  assign bus.in_ready = rdy;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DATA: begin
        if (accept) begin
          if (bus.in_last) begin
            state_nxt = (int'(len_in) < MIN_LEN) ? PAD : FCS;
          end else if (int'(len_in) >= MAX_LEN) begin
            state_nxt = TRUNC;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      TRUNC:   if (accept && bus.in_last) state_nxt = FCS;
      PAD:     if (ld_ok && int'(len_in) >= MIN_LEN) state_nxt = FCS;
      FCS:     if (ld_ok && cnt == 16'd3) state_nxt = IFG;
      IFG:     if (ld_ok && int'(cnt) + 1 >= IFG_CYCLES) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_data = 8'h00;
    load_eof  = 1'b0;
    crc_en    = 1'b0;
    crc_clr   = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        load      = accept;
        load_data = bus.in_data;
        crc_en    = accept;
      end
      PAD: begin
        load   = ld_ok;
        crc_en = ld_ok;
      end
      FCS: begin
        load      = ld_ok;
        load_data = fcs[{cnt[1:0], 3'b000} +: 8];
        load_eof  = (cnt == 16'd3);
      end
      IFG:     crc_clr = (state_nxt == IDLE);
      default: ;
    endcase
  end

  crc32_d8_reg u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (crc_clr),
    .en      (crc_en),
    .data    (load_data),
    .crc     (crc)
  );

  // cnt indexes FCS bytes, then counts IFG cycles starting with the eof transfer cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.tx_eof   <= 1'b0;
      len          <= 11'd0;
      cnt          <= 16'd0;
      trunc        <= 1'b0;
    end else begin
      if (ld_ok) begin
        bus.tx_valid <= load;
        bus.tx_eof   <= load_eof;
        if (load) bus.tx_data <= load_data;
      end
      if (crc_en) len <= len_in;
      if (state_nxt != state) begin
        cnt <= 16'd0;
      end else if (ld_ok && ((state == FCS) || (state == IFG))) begin
        cnt <= cnt + 16'd1;
      end
      if ((state == TRUNC) && (state_nxt == FCS)) begin
        trunc <= 1'b1;
      end else if (state == IFG) begin
        trunc <= 1'b0;
      end
    end
  end

`ifdef ETH_MAC_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_frames <= 32'd0;
      stat_trunc  <= 16'd0;
    end else begin
      if (bus.tx_valid && bus.tx_eof && !bus.tx_pause) stat_frames <= stat_frames + 32'd1;
      if ((state != TRUNC) && (state_nxt == TRUNC)) stat_trunc <= stat_trunc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_mac_tx.sv
// Bench for eth_mac_tx: default-parameter instance plus a MIN_LEN=0 instance for the check vector.
module tb_eth_mac_tx;
  import eth_pkg::*;

  localparam int IFG = 12;
  typedef logic [7:0] byte_q_t[$];

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #4 clk = ~clk;

  initial begin
    #(8 * 95000);
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  eth_mac_tx_if bus_a ();
  eth_mac_tx_if bus_b ();

  logic       sel = 1'b0;
  logic       d_valid = 1'b0, d_last = 1'b0, d_pause = 1'b0;
  logic [7:0] d_data = 8'h00;

  assign bus_a.in_valid = d_valid && !sel;
  assign bus_a.in_data  = d_data;
  assign bus_a.in_last  = d_last;
  assign bus_a.tx_pause = d_pause;
  assign bus_b.in_valid = d_valid && sel;
  assign bus_b.in_data  = d_data;
  assign bus_b.in_last  = d_last;
  assign bus_b.tx_pause = d_pause;

  mac_tx_state_t st_a, st_b, m_state;
  logic       m_ready, m_valid, m_eof;
  logic [7:0] m_data;
  assign m_ready = sel ? bus_b.in_ready : bus_a.in_ready;
  assign m_valid = sel ? bus_b.tx_valid : bus_a.tx_valid;
  assign m_eof   = sel ? bus_b.tx_eof   : bus_a.tx_eof;
  assign m_data  = sel ? bus_b.tx_data  : bus_a.tx_data;
  assign m_state = sel ? st_b : st_a;

`ifdef ETH_MAC_TX_STATS_EN
  logic [31:0] sf_a, sf_b;
  logic [15:0] stt_a, stt_b;
`endif

  eth_mac_tx u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_a),
    .dbg_state (st_a)
`ifdef ETH_MAC_TX_STATS_EN
    ,
    .stat_frames (sf_a),
    .stat_trunc  (stt_a)
`endif
  );

  eth_mac_tx #(.MIN_LEN(0)) u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_b),
    .dbg_state (st_b)
`ifdef ETH_MAC_TX_STATS_EN
    ,
    .stat_frames (sf_b),
    .stat_trunc  (stt_b)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: {eof, data} per expected PCS transfer
  logic [8:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         out_cnt = 0, frame_len = 0, gap = 0, last_gap = -1;
  bit         seen_eof = 1'b0;
  bit         prev_hold = 1'b0;
  logic [8:0] prev_val;

  always @(negedge clk) begin
    if (!mon_en || !reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold", {m_eof, m_data}, prev_val);
      prev_hold = m_valid && d_pause;
      prev_val  = {m_eof, m_data};
      if (m_valid && !d_pause) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", exp_q.size(), 1);
        end else begin
          check("byte", {m_eof, m_data}, exp_q.pop_front());
        end
        out_cnt++;
        if (seen_eof) begin
          last_gap = gap;
          seen_eof = 1'b0;
        end
        if (m_eof) begin
          frame_len = out_cnt;
          out_cnt   = 0;
          seen_eof  = 1'b1;
          gap       = 0;
        end
      end else if (!m_valid && seen_eof) begin
        gap++;
      end
    end
  end

  // bit-serial reference CRC, no final inversion
  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic byte_q_t make_frame(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic push_expect(input logic [7:0] d[$], input int min_len);
    logic [7:0]  o[$];
    bit          tr;
    logic [31:0] c, f;
    tr = d.size() > ETH_MAX_LEN;
    for (int i = 0; i < d.size() && i < ETH_MAX_LEN; i++) o.push_back(d[i]);
    while (o.size() < min_len) o.push_back(8'h00);
    c = crc_model(o);
    f = tr ? c : ~c;
    foreach (o[i]) exp_q.push_back({1'b0, o[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), f[8*k +: 8]});
  endtask

  // driver: inputs change 1 time unit after posedge; handshake judged at negedge
  task automatic send_frame(input logic [7:0] d[$], input bit gaps, input int pause_from,
                            input int abort_at, output int stalls);
    int waitc;
    stalls = 0;
    foreach (d[i]) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", m_ready, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
      if (i == pause_from) d_pause = 1'b1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        d_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      d_valid = 1'b1;
      d_data  = d[i];
      d_last  = (i == d.size() - 1);
      waitc   = 0;
      forever begin
        @(negedge clk);
        if (m_ready) break;
        if (pause_from >= 0 && i >= pause_from) stalls++;
        waitc++;
        if (waitc > 2000) begin
          check("in_timeout", waitc, 0);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    if (pause_from >= 0) d_pause = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_cnt < n) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        check("pause_timeout", t, 0);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (IFG + 4) @(posedge clk);
    #1;
  endtask

  byte_q_t     fr, fr2;
  logic [7:0]  b8;
  logic [31:0] kf;
  int          st;
  int          lens[5] = '{1, 59, 60, 61, 1514};
  int          el;
`ifdef ETH_MAC_TX_STATS_EN
  logic [15:0] trunc0;
`endif

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", bus_a.tx_valid, 1'b0);
    check("rst_tx_eof", bus_a.tx_eof, 1'b0);
    check("rst_tx_data", bus_a.tx_data, 8'h00);
    check("rst_in_ready", bus_a.in_ready, 1'b0);
    check("rst_state", st_a, IDLE);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // check vector "123456789" without padding
    sel = 1'b1;
    fr.delete();
    for (int k = 0; k < 9; k++) begin
      b8 = 8'h31 + 8'(k);
      fr.push_back(b8);
      exp_q.push_back({1'b0, b8});
    end
    kf = 32'hCBF43926;
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), kf[8*k +: 8]});
    send_frame(fr, 1'b0, -1, -1, st);
    drain();
    check("t1_len", frame_len, 13);
    sel = 1'b0;

    // short frame with input bubbles, padded to 60
    fr = make_frame(20);
    push_expect(fr, ETH_MIN_LEN);
    send_frame(fr, 1'b1, -1, -1, st);
    drain();
    check("t2_len", frame_len, 64);

    // length boundaries
    foreach (lens[j]) begin
      fr = make_frame(lens[j]);
      push_expect(fr, ETH_MIN_LEN);
      send_frame(fr, 1'b0, -1, -1, st);
      drain();
      el = ((lens[j] < ETH_MIN_LEN) ? ETH_MIN_LEN : lens[j]) + 4;
      check("len_bound", frame_len, el);
    end

    // 100-byte frame, unpaused then paused at byte 50 and FCS byte1
    fr = make_frame(100);
    push_expect(fr, ETH_MIN_LEN);
    send_frame(fr, 1'b0, -1, -1, st);
    drain();
    push_expect(fr, ETH_MIN_LEN);
    fork
      send_frame(fr, 1'b0, -1, -1, st);
      begin
        wait_out(50);
        d_pause = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        d_pause = 1'b0;
        wait_out(101);
        d_pause = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        d_pause = 1'b0;
      end
    join
    drain();
    check("t3_len", frame_len, 104);

    // back-to-back 64-byte frames: gap must be exactly IFG
    fr  = make_frame(64);
    fr2 = make_frame(64);
    push_expect(fr, ETH_MIN_LEN);
    push_expect(fr2, ETH_MIN_LEN);
    last_gap = -1;
    send_frame(fr, 1'b0, -1, -1, st);
    send_frame(fr2, 1'b0, -1, -1, st);
    drain();
    check("t4_gap", last_gap, IFG);

    // oversize frame: truncated, excess accepted even while paused
`ifdef ETH_MAC_TX_STATS_EN
    trunc0 = stt_a;
`endif
    fr = make_frame(1600);
    push_expect(fr, ETH_MIN_LEN);
    send_frame(fr, 1'b0, ETH_MAX_LEN, -1, st);
    check("t5_stalls", st, 0);
    drain();
    check("t5_len", frame_len, ETH_MAX_LEN + 4);
`ifdef ETH_MAC_TX_STATS_EN
    check("t5_stat_trunc", stt_a - trunc0, 16'd1);
`endif

    // reset mid-frame, then a clean frame
    mon_en = 1'b0;
    fr = make_frame(64);
    send_frame(fr, 1'b0, -1, 30, st);
    @(negedge clk);
    check("t6_tx_valid", bus_a.tx_valid, 1'b0);
    check("t6_tx_eof", bus_a.tx_eof, 1'b0);
    check("t6_tx_data", bus_a.tx_data, 8'h00);
    check("t6_state", st_a, IDLE);
    @(posedge clk);
    #1;
    exp_q.delete();
    out_cnt  = 0;
    seen_eof = 1'b0;
    mon_en   = 1'b1;
    fr = make_frame(64);
    push_expect(fr, ETH_MIN_LEN);
    send_frame(fr, 1'b0, -1, -1, st);
    drain();
    check("t6_len", frame_len, 68);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
